// File: rtl/scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scan_ctrl
// Description : Time-multiplexed scan controller for an eight-digit display
//               that is driven through a 74x138-style 3-to-8 decoder.
//               Digits are stepped 0..7. Each digit gets BLANK dark cycles
//               followed by DIV lit cycles. New digit data is double-buffered
//               and swapped in only at a frame boundary (a wrapping 7 -> 0),
//               or at once while the scanner is idle.
//
// Ports       : clk   - single clock, rising edge
//               rst   - asynchronous, active-high reset
//               en    - scan enable (1 = scan, 0 = idle)
//               load  - single-cycle strobe that captures din as pending data
//               din   - eight 4-bit digits, digit k = din[4k+3:4k]
//               mask  - per-digit enable, mask[k]=1 lights digit k
//               a     - digit select to the decoder
//               g1    - decoder active-high enable
//               g2a   - decoder active-low enable
//               g2b   - decoder active-low enable
//               nib   - value of the digit currently selected by a
//               frame - one-cycle pulse when a wraps from 7 to 0
//               ack   - one-cycle pulse when pending data becomes displayed
//
// Revision    : 1.0  initial release
// ============================================================================
module scan_ctrl #(
  parameter int DIV   = 4,  // lit cycles per digit, 1..65535
  parameter int BLANK = 2   // dark cycles before each digit, 0..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] din,
  input  logic [7:0]  mask,
  output logic [2:0]  a,
  output logic        g1,
  output logic        g2a,
  output logic        g2b,
  output logic [3:0]  nib,
  output logic        frame,
  output logic        ack
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  // With BLANK=0 the blanking state is never visited: both the idle exit and
  // the end of a digit go straight to SHOW.
  localparam logic [1:0]  S_NEXT     = (BLANK > 0) ? S_BLANK : S_SHOW;
  localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
  localparam logic [15:0] BLANK_LAST = 16'((BLANK > 0) ? (BLANK - 1) : 0);

  // FSM and sequencing state
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  a_q, a_d;

  // Double-buffered digit data
  logic [31:0] disp_q, disp_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;

  // Registered outputs
  logic        g1_q, g1_d;
  logic        g2a_q, g2a_d;
  logic        g2b_q, g2b_d;
  logic [3:0]  nib_q, nib_d;
  logic        frame_q, frame_d;
  logic        ack_q, ack_d;

  // Decoded events for the current edge
  logic        wrap;   // end of SHOW on digit 7
  logic        apply;  // pending data moves to the display this edge

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      a_q          <= 3'd0;
      disp_q       <= 32'd0;
      pend_q       <= 32'd0;
      pend_valid_q <= 1'b0;
      g1_q         <= 1'b0;
      g2a_q        <= 1'b1;
      g2b_q        <= 1'b1;
      nib_q        <= 4'd0;
      frame_q      <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      g1_q         <= g1_d;
      g2a_q        <= g2a_d;
      g2b_q        <= g2b_d;
      nib_q        <= nib_d;
      frame_q      <= frame_d;
      ack_q        <= ack_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: digit timing and digit stepping
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    wrap    = 1'b0;

    if (!en) begin
      // Dropping enable abandons the frame without a frame pulse.
      state_d = S_IDLE;
      cnt_d   = 16'd0;
      a_d     = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_NEXT;
          cnt_d   = 16'd0;
          a_d     = 3'd0;
        end

        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end

        S_SHOW: begin
          if (cnt_q == DIV_LAST) begin
            state_d = S_NEXT;
            cnt_d   = 16'd0;
            a_d     = a_q + 3'd1;
            wrap    = (a_q == 3'd7);
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
          a_d     = 3'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output and data-path logic. Outputs are computed from the next state so
  // that, once registered, they line up with the state they describe.
  // --------------------------------------------------------------------------
  always_comb begin
    // Pending data is taken at a frame boundary, or immediately while idle
    // since no frame is being drawn then.
    apply = pend_valid_q & ((state_q == S_IDLE) | wrap);

    disp_d = apply ? pend_q : disp_q;

    // A load on the apply edge still lands in pending (the old pending value
    // is the one that goes to the display), so valid stays set.
    pend_d       = load ? din : pend_q;
    pend_valid_d = load | (pend_valid_q & ~apply);

    g1_d    = (state_d == S_SHOW) & mask[a_d];
    g2a_d   = (state_d != S_SHOW);
    g2b_d   = (state_d != S_SHOW);
    nib_d   = 4'(disp_d >> {a_d, 2'b00});
    frame_d = wrap;
    ack_d   = apply;
  end

  assign a     = a_q;
  assign g1    = g1_q;
  assign g2a   = g2a_q;
  assign g2b   = g2b_q;
  assign nib   = nib_q;
  assign frame = frame_q;
  assign ack   = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_ctrl
// Description : Self-checking bench for scan_ctrl (DIV=4, BLANK=2) plus a
//               second instance built with BLANK=0.
// Revision    : 1.0  initial release
// ============================================================================
module tb_scan_ctrl;

  localparam int DIV_T   = 4;
  localparam int BLANK_T = 2;
  localparam int PER     = DIV_T + BLANK_T;  // cycles per digit
  localparam int FRM     = 8 * PER;          // cycles per frame

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        en   = 1'b0;
  logic        load = 1'b0;
  logic [31:0] din  = 32'd0;
  logic [7:0]  mask = 8'hFF;

  logic [2:0] a, a0;
  logic       g1, g2a, g2b, frame, ack;
  logic       g1_0, g2a_0, g2b_0, frame_0, ack_0;
  logic [3:0] nib, nib_0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  scan_ctrl #(.DIV(DIV_T), .BLANK(BLANK_T)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din), .mask(mask),
    .a(a), .g1(g1), .g2a(g2a), .g2b(g2b), .nib(nib), .frame(frame), .ack(ack)
  );

  scan_ctrl #(.DIV(DIV_T), .BLANK(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din), .mask(mask),
    .a(a0), .g1(g1_0), .g2a(g2a_0), .g2b(g2b_0), .nib(nib_0),
    .frame(frame_0), .ack(ack_0)
  );

  // --------------------------------------------------------------------------
  // Reference model. k counts consecutive enabled edges since the last idle
  // period (0 = idle). The scan position is k-1; digit, blank/show phase and
  // frame boundaries follow from plain division by the digit/frame lengths.
  // --------------------------------------------------------------------------
  int          k;
  logic [31:0] m_disp, m_pend;
  logic        m_pv;
  logic [2:0]  e_a;
  logic        e_g1, e_g2, e_frame, e_ack;
  logic [3:0]  e_nib;

  always @(posedge clk or posedge rst) begin : ref_model
    int          kn, p;
    logic        wr, ap, lit;
    logic [2:0]  dg;
    logic [31:0] nd;
    if (rst) begin
      k <= 0; m_disp <= 32'd0; m_pend <= 32'd0; m_pv <= 1'b0;
      e_a <= 3'd0; e_g1 <= 1'b0; e_g2 <= 1'b1; e_nib <= 4'd0;
      e_frame <= 1'b0; e_ack <= 1'b0;
    end else begin
      wr  = en && (k > 0) && (k % FRM == 0);
      ap  = m_pv && ((k == 0) || wr);
      nd  = ap ? m_pend : m_disp;
      kn  = en ? k + 1 : 0;
      p   = (kn > 0) ? kn - 1 : 0;
      dg  = 3'((p / PER) % 8);
      lit = (kn > 0) && ((p % PER) >= BLANK_T);
      k      <= kn;
      m_disp <= nd;
      if (load) begin
        m_pend <= din;
        m_pv   <= 1'b1;
      end else if (ap) begin
        m_pv <= 1'b0;
      end
      e_a     <= dg;
      e_g1    <= lit && mask[dg];
      e_g2    <= !lit;
      e_nib   <= nd[4*dg +: 4];
      e_frame <= wr;
      e_ack   <= ap;
    end
  end

  // --------------------------------------------------------------------------
  task automatic test_reset();
    #1 rst = 1'b1;
    en = 1'b0; load = 1'b0; mask = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({a, g1, g2a, g2b, nib, frame, ack} !== 12'b000_0_1_1_0000_0_0)
        $display("FAIL reset_values got a=%0d g1=%b g2a=%b g2b=%b nib=%h frame=%b ack=%b required a=0 g1=0 g2a=1 g2b=1 nib=0 frame=0 ack=0",
                 a, g1, g2a, g2b, nib, frame, ack);
      else passed++;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a, g1, g2a, g2b, nib, frame, ack} !== {e_a, e_g1, e_g2, e_g2, e_nib, e_frame, e_ack})
      $display("FAIL idle_after_reset got %0d/%b/%b/%b/%h/%b/%b required %0d/%b/%b/%b/%h/%b/%b",
               a, g1, g2a, g2b, nib, frame, ack, e_a, e_g1, e_g2, e_g2, e_nib, e_frame, e_ack);
    else passed++;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_scan();
    int frames = 0;
    en = 1'b1; mask = 8'hFF;
    for (int c = 0; c < 2 * FRM + 4; c++) begin
      @(negedge clk);
      checks++;
      if ({a, g1, g2a, g2b, nib, frame, ack} !== {e_a, e_g1, e_g2, e_g2, e_nib, e_frame, e_ack})
        $display("FAIL scan k=%0d got %0d/%b/%b/%b/%h/%b/%b required %0d/%b/%b/%b/%h/%b/%b",
                 k, a, g1, g2a, g2b, nib, frame, ack, e_a, e_g1, e_g2, e_g2, e_nib, e_frame, e_ack);
      else passed++;
      if (frame) frames++;
    end
    checks++;
    if (frames !== 2)
      $display("FAIL scan_frame_count got %0d required 2", frames);
    else passed++;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_frame_load();
    int acks  = 0;
    int guard = 0;
    bit after = 1'b0;
    while ((k % FRM != 20) && (guard < 200)) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 200) $display("FAIL frame_load_wait got timeout required mid-frame position");
    else passed++;
    din = 32'h87654321; load = 1'b1;
    for (int c = 0; c < FRM + 40; c++) begin
      @(negedge clk);
      load = 1'b0;
      checks++;
      if ({a, g1, g2a, g2b, nib, frame, ack} !== {e_a, e_g1, e_g2, e_g2, e_nib, e_frame, e_ack})
        $display("FAIL frame_load k=%0d got %0d/%b/%b/%b/%h/%b/%b required %0d/%b/%b/%b/%h/%b/%b",
                 k, a, g1, g2a, g2b, nib, frame, ack, e_a, e_g1, e_g2, e_g2, e_nib, e_frame, e_ack);
      else passed++;
      if (ack) begin
        acks++;
        after = 1'b1;
      end
      if (after && g1) begin
        checks++;
        if (nib !== 4'(a) + 4'd1)
          $display("FAIL frame_load_digit got nib=%h at a=%0d required %h", nib, a, 4'(a) + 4'd1);
        else passed++;
      end
    end
    checks++;
    if (acks !== 1) $display("FAIL frame_load_ack_count got %0d required 1", acks);
    else passed++;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_coincident();
    int acks = 0;
    bit sent = 1'b0;
    for (int c = 0; c < 2 * FRM + 20; c++) begin
      @(negedge clk);
      checks++;
      if ({a, g1, g2a, g2b, nib, frame, ack} !== {e_a, e_g1, e_g2, e_g2, e_nib, e_frame, e_ack})
        $display("FAIL coincident k=%0d got %0d/%b/%b/%b/%h/%b/%b required %0d/%b/%b/%b/%h/%b/%b",
                 k, a, g1, g2a, g2b, nib, frame, ack, e_a, e_g1, e_g2, e_g2, e_nib, e_frame, e_ack);
      else passed++;
      if (ack) begin
        acks++;
        checks++;
        if (nib !== ((acks == 1) ? 4'hA : 4'hB))
          $display("FAIL coincident_ack_nib got %h required %h", nib, (acks == 1) ? 4'hA : 4'hB);
        else passed++;
      end
      load = 1'b0;
      if (c == 5) begin
        din = 32'hAAAAAAAA; load = 1'b1;
      end
      // Next edge is the 7 -> 0 wrap: load exactly on it.
      if (c > 6 && !sent && k > 0 && (k % FRM == 0)) begin
        din = 32'hBBBBBBBB; load = 1'b1; sent = 1'b1;
      end
    end
    checks++;
    if (acks !== 2) $display("FAIL coincident_ack_count got %0d required 2", acks);
    else passed++;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_mask();
    int lit = 0;
    mask = 8'h05;
    for (int c = 0; c < FRM; c++) begin
      @(negedge clk);
      checks++;
      if ({a, g1, g2a, g2b, nib, frame, ack} !== {e_a, e_g1, e_g2, e_g2, e_nib, e_frame, e_ack})
        $display("FAIL mask k=%0d got %0d/%b/%b/%b/%h/%b/%b required %0d/%b/%b/%b/%h/%b/%b",
                 k, a, g1, g2a, g2b, nib, frame, ack, e_a, e_g1, e_g2, e_g2, e_nib, e_frame, e_ack);
      else passed++;
      if (g1) lit++;
    end
    checks++;
    if (lit !== 2 * DIV_T) $display("FAIL mask_lit_cycles got %0d required %0d", lit, 2 * DIV_T);
    else passed++;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_abort();
    int guard = 0;
    mask = 8'hFF;
    while (!(e_a == 3'd3 && e_g1) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 100) $display("FAIL abort_wait got timeout required SHOW at a=3");
    else passed++;
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({a, g1, g2a, g2b, frame} !== 7'b000_0_1_1_0)
      $display("FAIL abort_en got a=%0d g1=%b g2a=%b g2b=%b frame=%b required a=0 g1=0 g2a=1 g2b=1 frame=0",
               a, g1, g2a, g2b, frame);
    else passed++;
    en = 1'b1;
    guard = 0;
    while (!e_g1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 20 || g1 !== 1'b1) $display("FAIL abort_show got g1=%b required 1", g1);
    else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({g1, g2a, g2b, a} !== 6'b0_1_1_000)
      $display("FAIL abort_async_rst got g1=%b g2a=%b g2b=%b a=%0d required g1=0 g2a=1 g2b=1 a=0",
               g1, g2a, g2b, a);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({a, g1, g2a, g2b, nib, frame, ack} !== {e_a, e_g1, e_g2, e_g2, e_nib, e_frame, e_ack})
        $display("FAIL after_rst k=%0d got %0d/%b/%b/%b/%h/%b/%b required %0d/%b/%b/%b/%h/%b/%b",
                 k, a, g1, g2a, g2b, nib, frame, ack, e_a, e_g1, e_g2, e_g2, e_nib, e_frame, e_ack);
      else passed++;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      checks++;
      if ({a, g1, g2a, g2b, nib, frame, ack} !== {e_a, e_g1, e_g2, e_g2, e_nib, e_frame, e_ack})
        $display("FAIL random k=%0d got %0d/%b/%b/%b/%h/%b/%b required %0d/%b/%b/%b/%h/%b/%b",
                 k, a, g1, g2a, g2b, nib, frame, ack, e_a, e_g1, e_g2, e_g2, e_nib, e_frame, e_ack);
      else passed++;
      en   = ($urandom_range(0, 63) != 0);
      load = ($urandom_range(0, 19) == 0);
      din  = $urandom;
      mask = 8'($urandom);
    end
    load = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_blank0();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; load = 1'b0; mask = 8'hFF;
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if ({a0, g1_0, g2a_0, g2b_0, nib_0, frame_0, ack_0} !==
          {3'(((k - 1) / DIV_T) % 8), 1'b1, 1'b0, 1'b0, 4'h0,
           (k > 1) && ((k - 1) % (8 * DIV_T) == 0), 1'b0})
        $display("FAIL blank0 k=%0d got a=%0d g1=%b g2a=%b g2b=%b nib=%h frame=%b ack=%b required a=%0d g1=1 g2a=0 g2b=0 nib=0 frame=%b ack=0",
                 k, a0, g1_0, g2a_0, g2b_0, nib_0, frame_0, ack_0,
                 ((k - 1) / DIV_T) % 8, (k > 1) && ((k - 1) % (8 * DIV_T) == 0));
      else passed++;
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_scan();
    test_frame_load();
    test_coincident();
    test_mask();
    test_abort();
    test_random();
    test_blank0();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter DIV, default 4, SHALL set the clock cycles each digit is shown (legal 1..65535).
REQ-002 Parameter BLANK, default 2, SHALL set the blanking cycles before each digit (legal 0..255).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 en  input  1  SHALL be the scan enable; 1 = scan, 0 = idle.
REQ-006 load  input  1  SHALL be the single-cycle request to capture din.
REQ-007 din  input  32  SHALL be the eight 4-bit digit values; digit k = din[4k+3:4k].
REQ-008 mask  input  8  SHALL be the per-digit enable; mask[k]=1 shows digit k.
REQ-009 a  output  3  SHALL be the digit select driven to the 3-to-8 decoder.
REQ-010 g1  output  1  SHALL be the decoder active-high enable.
REQ-011 g2a  output  1  SHALL be the first decoder active-low enable.
REQ-012 g2b  output  1  SHALL be the second decoder active-low enable.
REQ-013 nib  output  4  SHALL be the value of the digit currently selected by a.
REQ-014 frame  output  1  SHALL be the one-cycle pulse marking wrap of a from 7 to 0.
REQ-015 ack  output  1  SHALL be the one-cycle pulse marking that pending data became the displayed data.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The FSM SHALL have exactly three states: IDLE, BLANK, SHOW.
REQ-018 IDLE -> BLANK SHALL occur on the first edge with en=1; a SHALL be 0 on entry.
REQ-019 BLANK SHALL last exactly BLANK cycles, then go to SHOW; with BLANK=0, BLANK SHALL be skipped and SHOW entered directly.
REQ-020 SHOW SHALL last exactly DIV cycles.
REQ-021 At the end of SHOW, a SHALL increment by 1 mod 8 and the FSM SHALL enter BLANK (or SHOW if BLANK=0).
REQ-022 In SHOW, g1 SHALL equal mask[a], and g2a and g2b SHALL both be 0.
REQ-023 In IDLE and BLANK, g1 SHALL be 0, and g2a and g2b SHALL both be 1; the decoder therefore outputs all ones.
REQ-024 nib SHALL equal disp[4a+3:4a] in every state, where disp is the internal 32-bit displayed register.
REQ-025 load=1 SHALL write din into a 32-bit pending register and set pend_valid; a later load SHALL overwrite pending data not yet applied.
REQ-026 At the SHOW-end edge where a goes 7 -> 0: frame SHALL pulse for one cycle; if pend_valid=1, then disp <= pending, ack SHALL pulse for one cycle, and pend_valid SHALL clear.
REQ-027 load coincident with the REQ-026 edge: the old pending value SHALL be applied, the new din SHALL be stored as pending, and pend_valid SHALL remain 1.
REQ-028 load while en=0 SHALL be stored as pending; in IDLE, pending data SHALL be applied on the next edge with ack pulsing, since no frame is in progress.
REQ-029 en falling to 0 in any state SHALL move the FSM to IDLE on the next edge, with a <= 0, counters cleared, and no frame pulse.
REQ-030 mask changes SHALL take effect on g1 at the next edge; mask SHALL NOT alter timing or a sequencing.

Reset
REQ-031 rst=1 SHALL immediately force: state IDLE, a=0, g1=0, g2a=1, g2b=1, nib=0, frame=0, ack=0, disp=0, pending=0, pend_valid=0, all counters 0.
REQ-032 Reset asserted mid-SHOW SHALL drop g1 without waiting for a clock edge.
REQ-033 After rst deasserts, the block SHALL behave as a fresh IDLE entry.

Verification (DIV=4, BLANK=2)
REQ-034 Scan timing: rst, then en=1, mask=FF -> per digit, g1=0 for 2 cycles then g1=1 for 4 cycles; a steps 0..7; frame pulses once per 48 cycles.
REQ-035 Frame-synchronous load: din=87654321 loaded mid-frame -> nib unchanged until the 7->0 wrap, then ack=1 for one cycle and nib follows 1,2,...,8 on a=0..7.
REQ-036 Coincident load: load din=AAAAAAAA, then load din=BBBBBBBB on the wrap edge -> AAAAAAAA displayed with ack; BBBBBBBB shown after the next wrap with a second ack.
REQ-037 Masking: mask=0x05 -> g1=1 only during SHOW of a=0 and a=2; g2a=g2b=0 during every SHOW.
REQ-038 Abort paths: en=0 mid-SHOW at a=3 -> next cycle IDLE, a=0, g1=0, g2a=g2b=1; async rst mid-SHOW -> g1=0 before the next clk edge.
REQ-039 BLANK=0 build: with en=1 -> g1 stays 1 continuously across digit changes and a changes every 4 cycles.
